// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a hex
// passthrough mode; result and overflow flag are held until the next DONE.
module bin2bcd_seq #(
  parameter int IN_W   = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [IN_W-1:0]       bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int OW = 4 * DIGITS;
  localparam int BW = 4 * (DIGITS + 1);
  localparam int SW = IN_W + BW;
  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sr;
  logic [SW-1:0] adj;
  logic [SW-1:0] shifted;
  logic [OW-1:0] hex_ext;

  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);
  assign hex_ext = OW'(bin_i);
  assign shifted = {adj[SW-2:0], 1'b0};

  // Add 3 to every BCD digit that is 5 or more before the next shift.
  always_comb begin
    adj = sr;
    for (int d = 0; d <= DIGITS; d++) begin
      if (sr[IN_W+4*d +: 4] >= 4'd5) begin
        adj[IN_W+4*d +: 4] = sr[IN_W+4*d +: 4] + 4'd3;
      end
    end
  end

  // Control FSM plus datapath registers; digit DIGITS flags overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      bcd_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (mode_i) begin
              sr    <= {{BW{1'b0}}, bin_i};
              cnt   <= CW'(IN_W);
              state <= SHIFT;
            end else begin
              bcd_o <= hex_ext;
              ovf_o <= 1'b0;
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            bcd_o <= sr[IN_W +: OW];
            ovf_o <= |sr[SW-1 -: 4];
            state <= DONE;
          end else begin
            sr  <= shifted;
            cnt <= cnt - CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
